aes_key_schedule: RTL and testbench
===================================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  request to expand key; accepted only when busy=0.
REQ-004 SHALL have port: key  input  [0:127]  AES-128 cipher key, FIPS-197 byte order, byte n at bits [8n:8n+7].
REQ-005 SHALL have port: busy  output  1  high from the cycle after start is accepted until the round-10 key is accepted.
REQ-006 SHALL have port: rk_valid  output  1  round_key/round_idx hold a valid round key.
REQ-007 SHALL have port: rk_ready  input  1  downstream AddRoundKey stage accepts the current round key.
REQ-008 SHALL have port: round_key  output  [0:127]  round key in state layout: byte of row r, column c at bits [32r+8c : 32r+8c+7].
REQ-009 SHALL have port: round_idx  output  [3:0]  index 0..10 of round_key.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after round 10 is accepted.

Function
REQ-011 SHALL implement FSM states IDLE and RUN; reset state IDLE.
REQ-012 In IDLE, start=1 SHALL register key as words w0..w3 (w0 = bytes 0..3), set round_idx=0, enter RUN on the next edge.
REQ-013 In IDLE, start=0 SHALL hold all registers; rk_valid=0, busy=0.
REQ-014 In RUN, rk_valid SHALL be 1 and busy SHALL be 1.
REQ-015 Round key SHALL be presented in the cycle after start is accepted (latency 1).
REQ-016 round_key SHALL be the transpose of the word register: word c byte r maps to row r, column c.
REQ-017 While rk_valid=1 and rk_ready=0, round_key and round_idx SHALL remain unchanged.
REQ-018 Transfer SHALL occur on a rising edge with rk_valid=1 and rk_ready=1.
REQ-019 On transfer with round_idx<10, words SHALL be updated per FIPS-197: t = SubWord(RotWord(w3)) XOR {Rcon,00,00,00}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'; round_idx increments.
REQ-020 Rcon for computing round i (1..10) SHALL be 01,02,04,08,10,20,40,80,1b,36; it SHALL derive from round_idx with no separate counter.
REQ-021 SubWord SHALL use four combinational FIPS-197 S-box lookups; the next key SHALL be ready one transfer later, so rk_ready held high yields one key per cycle.
REQ-022 On transfer with round_idx=10, the FSM SHALL enter IDLE, drive rk_valid=0 and busy=0 next cycle, and pulse done=1 for exactly one cycle.
REQ-023 start asserted while in RUN SHALL be ignored; key SHALL not be re-sampled.
REQ-024 start in the done cycle SHALL be accepted, since the FSM is in IDLE.
REQ-025 round_idx SHALL never exceed 10; no wrap-around.
REQ-026 round_key and round_idx SHALL retain the last round-10 values in IDLE until the next start.

Reset
REQ-027 rst=1 SHALL force IDLE next edge with rk_valid=0, busy=0, done=0, round_idx=0, round_key=0, word registers=0.
REQ-028 rst SHALL take priority over start and transfer.
REQ-029 rst mid-expansion SHALL abort it with no done pulse; a new start is needed to resume.

Verification
REQ-030 FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> next cycle round_idx=0, round_key=2b28ab097eaef7cf15d2154f16a6883c; 11 consecutive valid cycles, then done pulse.
REQ-031 Same run -> round_idx=1 key equals transpose of a0fafe1788542cb123a339392a6c7605; round_idx=10 key equals transpose of d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 Backpressure: rk_ready toggled randomly -> round_key/round_idx stable while rk_ready=0; the 11 accepted keys match REQ-031; exactly one done.
REQ-033 start pulsed at round_idx=4 with different key -> ignored, sequence continues on original key.
REQ-034 rst asserted at round_idx=6 -> next cycle all outputs zero, no done; start with all-zero key -> round 1 key equals transpose of 62636363626363636263636362636363.
REQ-035 start held high across done -> new expansion begins; rk_valid back at 1 the cycle after done.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// Handshake bundle for aes_key_schedule: key request, round-key stream and status.
// The slave modport is the key-schedule side; the master modport is the requester/consumer.
interface aes_key_schedule_if;
    logic           start;
    logic [0:127]   key;
    logic           busy;
    logic           rk_valid;
    logic           rk_ready;
    logic [0:127]   round_key;
    logic [3:0]     round_idx;
    logic           done;

    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, round_key, round_idx, done
    );

    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, round_key, round_idx, done
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per accepted transfer (rk_valid/rk_ready).
// Round keys are presented in state layout (row r, column c); done pulses after round 10.
module aes_key_schedule (
    input  logic              clk,
    input  logic              rst,
    aes_key_schedule_if.slave ks
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [3:0][31:0]  w_q, w_d;
    logic [3:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic [31:0]       t_word;

    // Rcon for the round being computed (idx_q + 1), taken straight from the index.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (ks.start) state_d = RUN;
            RUN:     if (ks.rk_ready && idx_q == 4'd10) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : next_words
        w_d    = w_q;
        idx_d  = idx_q;
        done_d = 1'b0;
        t_word = sub_word({w_q[3][23:0], w_q[3][31:24]}) ^ {rcon_of(idx_q), 24'h000000};
        if (state_q == IDLE) begin
            if (ks.start) begin
                w_d[0] = ks.key[0:31];
                w_d[1] = ks.key[32:63];
                w_d[2] = ks.key[64:95];
                w_d[3] = ks.key[96:127];
                idx_d  = '0;
            end
        end else if (ks.rk_ready) begin
            if (idx_q == 4'd10) begin
                done_d = 1'b1;
            end else begin
                // Each new word chains off the one just produced, as in FIPS-197.
                w_d[0] = w_q[0] ^ t_word;
                w_d[1] = w_q[1] ^ w_d[0];
                w_d[2] = w_q[2] ^ w_d[1];
                w_d[3] = w_q[3] ^ w_d[2];
                idx_d  = idx_q + 4'd1;
            end
        end
    end

    always_comb begin : outputs
        ks.rk_valid  = (state_q == RUN);
        ks.busy      = (state_q == RUN);
        ks.round_idx = idx_q;
        ks.done      = done_q;
        ks.round_key = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                ks.round_key[32*r + 8*c +: 8] = w_q[c][31 - 8*r -: 8];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a byte-level FIPS-197 key expansion model.
// The model's S-box is built from GF(2^8) inversion plus the affine map, not from a table.
module tb_aes_key_schedule;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_schedule_if ksif ();

    aes_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ksif.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_m [256];
    logic [0:127] exp_rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS byte string -> state layout (row r, column c = byte 4c+r).
    function automatic logic [0:127] tr(input logic [0:127] k);
        logic [0:127] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[32*r + 8*c +: 8] = k[8*(4*c + r) +: 8];
        return o;
    endfunction

    task automatic expand(input logic [0:127] k);
        logic [7:0] wb [44][4];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) wb[i][j] = k[8*(4*i + j) +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = wb[i-1][j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = sbox_m[wb[i-1][(j + 1) % 4]];
                tmp[0] = tmp[0] ^ rc;
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            for (int j = 0; j < 4; j++) wb[i][j] = wb[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 11; r++)
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    exp_rk[r][32*row + 8*c +: 8] = wb[4*r + c][row];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [0:127] k);
        ksif.start = 1'b1;
        ksif.key   = k;
        tick();
        ksif.start = 1'b0;
    endtask

    function automatic logic [0:127] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ksif.start = 1'b1;
        ksif.key = rand_key();
        ksif.rk_ready = 1'b1;
        tick();
        tick();
        total++; if ({ksif.rk_valid, ksif.busy, ksif.done} !== 3'b000) begin bad++;
            $display("FAIL reset_flags: got %b want 000", {ksif.rk_valid, ksif.busy, ksif.done}); end
        total++; if (ksif.round_idx !== 4'd0) begin bad++;
            $display("FAIL reset_idx: got %0d want 0", ksif.round_idx); end
        total++; if (ksif.round_key !== 128'h0) begin bad++;
            $display("FAIL reset_key: got %h want 0", ksif.round_key); end
        rst = 1'b0;
        ksif.start = 1'b0;
        tick();
        total++; if (ksif.rk_valid !== 1'b0) begin bad++;
            $display("FAIL idle_no_start: got rk_valid=%b want 0", ksif.rk_valid); end
    endtask

    task automatic test_fips_vector();
        logic [0:127] k, c0, c1, c10;
        k   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        c0  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
        c1  = 128'ha0fafe1788542cb123a339392a6c7605;
        c10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        expand(k);
        ksif.rk_ready = 1'b1;
        do_start(k);
        for (int i = 0; i <= 10; i++) begin
            total++; if ({ksif.rk_valid, ksif.busy, ksif.done} !== 3'b110) begin bad++;
                $display("FAIL fips_flags[%0d]: got %b want 110", i, {ksif.rk_valid, ksif.busy, ksif.done}); end
            total++; if (ksif.round_idx !== 4'(i)) begin bad++;
                $display("FAIL fips_idx[%0d]: got %0d want %0d", i, ksif.round_idx, i); end
            total++; if (ksif.round_key !== exp_rk[i]) begin bad++;
                $display("FAIL fips_key[%0d]: got %h want %h", i, ksif.round_key, exp_rk[i]); end
            if (i == 0) begin
                total++; if (ksif.round_key !== c0) begin bad++;
                    $display("FAIL fips_a1_rk0: got %h want %h", ksif.round_key, c0); end
            end
            if (i == 1) begin
                total++; if (ksif.round_key !== tr(c1)) begin bad++;
                    $display("FAIL fips_a1_rk1: got %h want %h", ksif.round_key, tr(c1)); end
            end
            if (i == 10) begin
                total++; if (ksif.round_key !== tr(c10)) begin bad++;
                    $display("FAIL fips_a1_rk10: got %h want %h", ksif.round_key, tr(c10)); end
            end
            tick();
        end
        total++; if ({ksif.rk_valid, ksif.busy, ksif.done} !== 3'b001) begin bad++;
            $display("FAIL fips_done: got %b want 001", {ksif.rk_valid, ksif.busy, ksif.done}); end
        total++; if (ksif.round_idx !== 4'd10 || ksif.round_key !== exp_rk[10]) begin bad++;
            $display("FAIL fips_retain: got idx=%0d key=%h want idx=10 key=%h", ksif.round_idx, ksif.round_key, exp_rk[10]); end
        tick();
        total++; if (ksif.done !== 1'b0 || ksif.round_idx !== 4'd10) begin bad++;
            $display("FAIL fips_done_pulse: got done=%b idx=%0d want done=0 idx=10", ksif.done, ksif.round_idx); end
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 3; n++) begin
            logic [0:127] k;
            int exp_i, cycles;
            logic r;
            k = rand_key();
            expand(k);
            ksif.rk_ready = 1'b0;
            do_start(k);
            exp_i = 0;
            cycles = 0;
            while (exp_i <= 10 && cycles < 300) begin
                total++; if (ksif.rk_valid !== 1'b1 || ksif.done !== 1'b0) begin bad++;
                    $display("FAIL bp_flags[%0d]: got valid=%b done=%b want 1/0", exp_i, ksif.rk_valid, ksif.done); end
                total++; if (ksif.round_idx !== 4'(exp_i) || ksif.round_key !== exp_rk[exp_i]) begin bad++;
                    $display("FAIL bp_key[%0d]: got idx=%0d key=%h want %h", exp_i, ksif.round_idx, ksif.round_key, exp_rk[exp_i]); end
                r = 1'($urandom_range(0, 1));
                ksif.rk_ready = r;
                tick();
                if (r) exp_i++;
                cycles++;
            end
            total++; if (cycles >= 300) begin bad++;
                $display("FAIL bp_timeout: got %0d accepted want 11", exp_i); end
            total++; if (ksif.done !== 1'b1 || ksif.rk_valid !== 1'b0) begin bad++;
                $display("FAIL bp_done: got done=%b valid=%b want 1/0", ksif.done, ksif.rk_valid); end
            ksif.rk_ready = 1'b0;
            tick();
            total++; if (ksif.done !== 1'b0) begin bad++;
                $display("FAIL bp_single_done: got %b want 0", ksif.done); end
        end
    endtask

    task automatic test_start_ignored();
        logic [0:127] ka;
        ka = rand_key();
        expand(ka);
        ksif.rk_ready = 1'b1;
        do_start(ka);
        for (int i = 0; i <= 10; i++) begin
            total++; if (ksif.round_idx !== 4'(i) || ksif.round_key !== exp_rk[i] || ksif.busy !== 1'b1) begin bad++;
                $display("FAIL ign_key[%0d]: got idx=%0d key=%h busy=%b want %h", i, ksif.round_idx, ksif.round_key, ksif.busy, exp_rk[i]); end
            ksif.start = (i == 4);
            ksif.key   = (i == 4) ? ~ka : ka;
            tick();
        end
        ksif.start = 1'b0;
        total++; if (ksif.done !== 1'b1) begin bad++;
            $display("FAIL ign_done: got %b want 1", ksif.done); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [0:127] k, z1;
        int n;
        k  = rand_key();
        z1 = 128'h62636363626363636263636362636363;
        expand(k);
        ksif.rk_ready = 1'b1;
        do_start(k);
        for (int i = 0; i < 6; i++) tick();
        total++; if (ksif.round_idx !== 4'd6 || ksif.round_key !== exp_rk[6]) begin bad++;
            $display("FAIL rstmid_pre: got idx=%0d key=%h want 6 %h", ksif.round_idx, ksif.round_key, exp_rk[6]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({ksif.rk_valid, ksif.busy, ksif.done} !== 3'b000 || ksif.round_idx !== 4'd0 || ksif.round_key !== 128'h0) begin bad++;
            $display("FAIL rstmid_zero: got flags=%b idx=%0d key=%h want all zero",
                     {ksif.rk_valid, ksif.busy, ksif.done}, ksif.round_idx, ksif.round_key); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ksif.rk_valid !== 1'b0 || ksif.done !== 1'b0) begin bad++;
                $display("FAIL rstmid_no_resume[%0d]: got valid=%b done=%b want 0/0", i, ksif.rk_valid, ksif.done); end
        end
        do_start(128'h0);
        total++; if (ksif.round_idx !== 4'd0 || ksif.round_key !== 128'h0) begin bad++;
            $display("FAIL zero_rk0: got idx=%0d key=%h want 0", ksif.round_idx, ksif.round_key); end
        tick();
        total++; if (ksif.round_idx !== 4'd1 || ksif.round_key !== tr(z1)) begin bad++;
            $display("FAIL zero_rk1: got idx=%0d key=%h want %h", ksif.round_idx, ksif.round_key, tr(z1)); end
        n = 0;
        while (ksif.done !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (ksif.done !== 1'b1 || n != 10) begin bad++;
            $display("FAIL zero_done: got done=%b after %0d cycles want 1 after 10", ksif.done, n); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [0:127] ka, kb;
        int n;
        ka = rand_key();
        kb = rand_key();
        expand(ka);
        ksif.rk_ready = 1'b1;
        ksif.start = 1'b1;
        ksif.key = ka;
        tick();
        ksif.key = kb;
        for (int i = 0; i <= 10; i++) begin
            total++; if (ksif.round_idx !== 4'(i) || ksif.round_key !== exp_rk[i]) begin bad++;
                $display("FAIL b2b_a[%0d]: got idx=%0d key=%h want %h", i, ksif.round_idx, ksif.round_key, exp_rk[i]); end
            tick();
        end
        total++; if (ksif.done !== 1'b1 || ksif.rk_valid !== 1'b0) begin bad++;
            $display("FAIL b2b_done: got done=%b valid=%b want 1/0", ksif.done, ksif.rk_valid); end
        tick();
        ksif.start = 1'b0;
        total++; if (ksif.rk_valid !== 1'b1 || ksif.done !== 1'b0 || ksif.round_idx !== 4'd0 || ksif.round_key !== tr(kb)) begin bad++;
            $display("FAIL b2b_restart: got valid=%b done=%b idx=%0d key=%h want 1 0 0 %h",
                     ksif.rk_valid, ksif.done, ksif.round_idx, ksif.round_key, tr(kb)); end
        expand(kb);
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++; if (ksif.round_idx !== 4'(i) || ksif.round_key !== exp_rk[i]) begin bad++;
                $display("FAIL b2b_b[%0d]: got idx=%0d key=%h want %h", i, ksif.round_idx, ksif.round_key, exp_rk[i]); end
        end
        n = 0;
        while (ksif.busy === 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n != 1 || ksif.done !== 1'b1) begin bad++;
            $display("FAIL b2b_b_done: got done=%b after %0d cycles want 1 after 1", ksif.done, n); end
        ksif.rk_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ksif.start = 1'b0;
        ksif.key = '0;
        ksif.rk_ready = 1'b0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
